// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: bus-programmed TX byte FIFO feeding a UART transmitter.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   wr_en, rd_en     bus write / read strobes
//   addr[1:0]        0 TXDATA, 1 STATUS, 2 CTRL, 3 reserved
//   wdata[31:0]      bus write data
//   rdata[31:0]      registered read data, valid the cycle after rd_en
//   tx_send          frame start request to the transmitter (high only in REQ)
//   tx_data[7:0]     byte for the transmitter, stable while tx_send is high
//   tx_busy          transmitter busy with a frame
//   irq              registered level interrupt: FIFO drained and FSM idle
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | no frame in progress; pop the head when enabled
// ST_REQ   | tx_send held high until the transmitter reports busy
// ST_DRAIN | frame in progress; wait for the transmitter to go idle
module uart_tx_ctrl #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        tx_send,
    output logic [7:0]  tx_data,
    input  logic        tx_busy,
    output logic        irq
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          full, empty;

    logic          ovf, en, irq_en;
    logic          wr_txdata, wr_status, wr_ctrl;
    logic          flush, push, ovf_set, pop;
    logic [7:0]    count_ext;
    logic [31:0]   rd_mux;
    logic          unused_wdata;

    assign full  = (count == CW'(FIFO_DEPTH));
    assign empty = (count == '0);

    assign wr_txdata = wr_en && (addr == 2'd0);
    assign wr_status = wr_en && (addr == 2'd1);
    assign wr_ctrl   = wr_en && (addr == 2'd2);

    assign flush   = wr_ctrl && wdata[1];
    // Full is judged on the registered count, so a pop in the same cycle
    // does not make room for the incoming byte.
    assign push    = wr_txdata && !full && !flush;
    assign ovf_set = wr_txdata && full;

    assign unused_wdata = ^wdata[31:8];

    // FSM next-state and outputs
    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        tx_send  = 1'b0;
        case (state)
            ST_IDLE: begin
                // empty comes from the registered count, so a byte pushed
                // this cycle into an empty FIFO waits one cycle.
                if (en && !empty) begin
                    pop      = 1'b1;
                    state_nx = ST_REQ;
                end
            end
            ST_REQ: begin
                tx_send = 1'b1;
                if (tx_busy) begin
                    state_nx = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!tx_busy) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // FIFO storage carries no reset; pointers and count define validity.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fifo_mem[wr_ptr] <= wdata[7:0];
        end
    end

    // Read mux
    assign count_ext = 8'(count);

    always_comb begin
        rd_mux = '0;
        case (addr)
            2'd1: rd_mux = {16'h0000, count_ext, 3'b000, (state != ST_IDLE),
                            ovf, tx_busy, empty, full};
            2'd2: rd_mux = {29'd0, irq_en, 1'b0, en};
            default: rd_mux = '0;
        endcase
    end

    // Datapath, registers, interrupt
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ovf     <= 1'b0;
            en      <= 1'b0;
            irq_en  <= 1'b0;
            tx_data <= 8'h00;
            rdata   <= 32'h0;
            irq     <= 1'b0;
        end else begin
            // A pop in the flush cycle still hands its byte to the
            // transmitter; only the queued bytes are discarded.
            if (pop) begin
                tx_data <= fifo_mem[rd_ptr];
            end

            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
            end

            if (ovf_set) begin
                ovf <= 1'b1;
            end else if (wr_status && wdata[3]) begin
                ovf <= 1'b0;
            end

            if (wr_ctrl) begin
                en     <= wdata[0];
                irq_en <= wdata[2];
            end

            irq <= irq_en && empty && (state == ST_IDLE);

            if (rd_en) begin
                rdata <= rd_mux;
            end
        end
    end

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, TX byte FIFO depth; SHALL be a power of two, 2..128.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 wr_en  input  1  bus write strobe, one transaction per cycle asserted.
REQ-005 rd_en  input  1  bus read strobe.
REQ-006 addr  input  2  word register select: 0 TXDATA, 1 STATUS, 2 CTRL, 3 reserved.
REQ-007 wdata  input  32  bus write data.
REQ-008 rdata  output  32  bus read data, registered.
REQ-009 tx_send  output  1  request to transmitter to start a frame.
REQ-010 tx_data  output  8  byte to transmit; stable while tx_send high.
REQ-011 tx_busy  input  1  transmitter busy with a frame.
REQ-012 irq  output  1  level interrupt, TX drained.

Function
REQ-013 Write TXDATA: SHALL push wdata[7:0] into FIFO if not full; else drop byte and set sticky OVF.
REQ-014 Full SHALL be evaluated before same-cycle pop: write to full FIFO is dropped even if a pop occurs that cycle.
REQ-015 Pop SHALL occur only from non-empty FIFO; a byte pushed into an empty FIFO is not poppable until the next cycle.
REQ-016 STATUS read: bit0 full, bit1 empty, bit2 tx_busy (raw input), bit3 OVF, bit4 state!=IDLE, bits[15:8] FIFO count zero-extended, others 0.
REQ-017 STATUS write: wdata[3]=1 SHALL clear OVF (W1C); other bits ignored.
REQ-018 CTRL bits: bit0 EN, bit1 FLUSH (self-clearing, reads 0), bit2 IRQ_EN; read returns {29'b0, IRQ_EN, 1'b0, EN}.
REQ-019 FLUSH SHALL empty FIFO (pointers/count to 0) in the write cycle; a push in the same cycle is discarded; in-flight byte is not aborted.
REQ-020 TXDATA read and reserved reads SHALL return 0; reserved writes ignored.
REQ-021 rdata SHALL be valid the cycle after rd_en; held otherwise.
REQ-022 FSM states IDLE, REQ, DRAIN.
REQ-023 IDLE: if EN and FIFO non-empty, pop head into tx_data, assert tx_send, go REQ.
REQ-024 REQ: hold tx_send=1 and tx_data stable until tx_busy sampled 1; then tx_send=0, go DRAIN.
REQ-025 DRAIN: tx_send=0; when tx_busy sampled 0, go IDLE.
REQ-026 Clearing EN SHALL not abort REQ/DRAIN; current byte completes, no further pop.
REQ-027 tx_send SHALL never be high outside REQ.
REQ-028 irq = IRQ_EN AND FIFO empty AND state IDLE, registered (1-cycle delay).
REQ-029 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1, 0..FIFO_DEPTH.
REQ-030 Bytes SHALL be transmitted in push order, no loss or duplication except REQ-013/019.

Reset
REQ-031 rst SHALL force state IDLE, FIFO empty, OVF=0, EN=0, IRQ_EN=0, tx_send=0, tx_data=0, rdata=0, irq=0, overriding all other inputs, including mid-frame.

Verification
REQ-032 EN=1, push 0x41,0x42,0x43; model busy rising 3 cycles after send, 10-cycle frame -> tx_data sequence 41,42,43, one send pulse-window per byte, tx_send drops the cycle after busy seen.
REQ-033 EN=0, push 9 bytes (depth 8) -> STATUS full=1, count=8, OVF=1; write STATUS 0x8 -> OVF=0; no tx_send.
REQ-034 Full FIFO with EN=1, push same cycle as pop -> byte dropped, OVF=1, count=7 next cycle.
REQ-035 During DRAIN of byte 0x55 with 4 queued, write CTRL FLUSH|EN -> 0x55 completes, count=0, FSM IDLE, no further send.
REQ-036 IRQ_EN=1, EN=1, push one byte -> irq 0 while sending, irq 1 one cycle after FSM returns IDLE empty.
REQ-037 Assert rst while in REQ with 3 bytes queued -> next cycle tx_send=0, count=0, STATUS reads 0x00000002.
